cpu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit processor. It fetches 16-bit instructions, presents the opcode to the combinational opcode decoder, and turns the decoder's level strobes into correctly timed, single-shot datapath actions. Those actions are memory request, register write, flag latch and PC update. It sits between instruction/data memory, the decoder, the ALU flag outputs and the register file.

---
 rtl/cpu_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute sequencer
// Turns level decoder strobes into single-shot memory, register, flag and PC actions.
module cpu_sequencer #(
  parameter int PC_W        = 8,
  parameter int BUS_TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [15:0]     imem_rdata_i,
  output logic [15:0]     ir_o,
  output logic [3:0]      opcode_o,
  input  logic            dec_we_mem_i,
  input  logic            dec_ld_mem_i,
  input  logic            dec_we_reg_i,
  input  logic            dec_en_jmp_i,
  input  logic            dec_use_imm_pc_i,
  input  logic            alu_carry_i,
  input  logic            alu_zero_i,
  output logic            flag_carry_o,
  output logic            flag_zero_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  input  logic            dmem_ack_i,
  output logic            reg_we_o,
  output logic [PC_W-1:0] pc_o,
  output logic            retire_o,
  output logic            bus_err_o,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int                CNT_W   = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BUS_TIMEOUT - 1);

  state_t            r_state, w_state_next;
  logic [PC_W-1:0]   r_pc, w_pc_next;
  logic [15:0]       r_ir, w_ir_next;
  logic              r_carry, w_carry_next;
  logic              r_zero, w_zero_next;
  logic              r_err, w_err_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [PC_W-1:0]   w_pc_inc;
  logic              w_cond;
  logic              w_taken;
  state_t            w_retire_state;

  assign w_pc_inc       = r_pc + PC_W'(1);
  assign w_retire_state = run_i ? S_FETCH : S_IDLE;

  // Jump conditions look at the flags registered by earlier instructions.
  always_comb begin
    w_cond = 1'b0;
    unique case (r_ir[11:10])
      2'b00: w_cond = r_zero;
      2'b01: w_cond = !r_zero;
      2'b10: w_cond = r_carry;
      2'b11: w_cond = 1'b0;
    endcase
  end
  assign w_taken = dec_use_imm_pc_i | w_cond;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_carry_next = r_carry;
    w_zero_next  = r_zero;
    w_err_next   = r_err;
    w_cnt_next   = '0;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    reg_we_o     = 1'b0;
    retire_o     = 1'b0;
    case (r_state)
      S_IDLE: if (run_i) w_state_next = S_FETCH;
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          w_ir_next    = imem_rdata_i;
          w_state_next = S_DECODE;
        end else if (r_cnt == CNT_MAX) begin
          w_err_next   = 1'b1;
          w_state_next = S_HALT;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        if (r_ir[15]) begin
          w_carry_next = alu_carry_i;
          w_zero_next  = alu_zero_i;
        end
        if (dec_en_jmp_i) begin
          w_pc_next    = w_taken ? r_ir[PC_W-1:0] : w_pc_inc;
          retire_o     = 1'b1;
          w_state_next = w_retire_state;
        end else if (dec_we_mem_i || dec_ld_mem_i) begin
          w_state_next = S_MEM;
        end else if (dec_we_reg_i) begin
          w_state_next = S_WB;
        end else begin
          w_pc_next    = w_pc_inc;
          retire_o     = 1'b1;
          w_state_next = w_retire_state;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec_we_mem_i;
        if (dmem_ack_i) begin
          if (dec_we_mem_i) begin
            w_pc_next    = w_pc_inc;
            retire_o     = 1'b1;
            w_state_next = w_retire_state;
          end else begin
            w_state_next = S_WB;
          end
        end else if (r_cnt == CNT_MAX) begin
          w_err_next   = 1'b1;
          w_state_next = S_HALT;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_we_o     = 1'b1;
        w_pc_next    = w_pc_inc;
        retire_o     = 1'b1;
        w_state_next = w_retire_state;
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_carry <= w_carry_next;
      r_zero  <= w_zero_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign imem_addr_o  = r_pc;
  assign pc_o         = r_pc;
  assign ir_o         = r_ir;
  assign opcode_o     = r_ir[15:12];
  assign flag_carry_o = r_carry;
  assign flag_zero_o  = r_zero;
  assign bus_err_o    = r_err;
  assign state_o      = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        run_i;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_rdata_i;
  logic [15:0] ir_o;
  logic [3:0]  opcode_o;
  logic        dec_we_mem_i, dec_ld_mem_i, dec_we_reg_i, dec_en_jmp_i, dec_use_imm_pc_i;
  logic        alu_carry_i, alu_zero_i;
  logic        flag_carry_o, flag_zero_o;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic        reg_we_o;
  logic [7:0]  pc_o;
  logic        retire_o;
  logic        bus_err_o;
  logic [2:0]  state_o;

  logic [15:0] prog [256];
  logic        imem_en;
  int          dmem_delay;
  int          dm_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(8), .BUS_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .run_i(run_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .ir_o(ir_o), .opcode_o(opcode_o),
    .dec_we_mem_i(dec_we_mem_i), .dec_ld_mem_i(dec_ld_mem_i), .dec_we_reg_i(dec_we_reg_i),
    .dec_en_jmp_i(dec_en_jmp_i), .dec_use_imm_pc_i(dec_use_imm_pc_i),
    .alu_carry_i(alu_carry_i), .alu_zero_i(alu_zero_i),
    .flag_carry_o(flag_carry_o), .flag_zero_o(flag_zero_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .reg_we_o(reg_we_o), .pc_o(pc_o), .retire_o(retire_o),
    .bus_err_o(bus_err_o), .state_o(state_o)
  );

  // Opcode map: 0 NOP, 1 LDI, 2 LD, 3 ST, 4 JMP imm, 5 JCC, 8-F ALU.
  always_comb begin
    dec_we_mem_i = 1'b0; dec_ld_mem_i = 1'b0; dec_we_reg_i = 1'b0;
    dec_en_jmp_i = 1'b0; dec_use_imm_pc_i = 1'b0;
    case (opcode_o)
      4'h1: dec_we_reg_i = 1'b1;
      4'h2: begin dec_ld_mem_i = 1'b1; dec_we_reg_i = 1'b1; end
      4'h3: dec_we_mem_i = 1'b1;
      4'h4: begin dec_en_jmp_i = 1'b1; dec_use_imm_pc_i = 1'b1; end
      4'h5: dec_en_jmp_i = 1'b1;
      default: dec_we_reg_i = opcode_o[3];
    endcase
  end

  assign imem_ack_i   = imem_req_o && imem_en;
  assign imem_rdata_i = prog[imem_addr_o];
  assign dmem_ack_i   = dmem_req_o && (dm_cnt == dmem_delay);

  always @(posedge clk) begin
    if (dmem_req_o && !dmem_ack_i) dm_cnt <= dm_cnt + 1;
    else dm_cnt <= 0;
  end

  task automatic reset_dut();
    rst_ni = 1'b0; run_i = 1'b0; imem_en = 1'b1; dmem_delay = 0;
    alu_carry_i = 1'b0; alu_zero_i = 1'b0;
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic wait_retire(output int cyc, output int n_we, output int n_req, output int n_dwe);
    bit done = 1'b0;
    cyc = 0; n_we = 0; n_req = 0; n_dwe = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (state_o != 3'd0) cyc++;
      if (reg_we_o) n_we++;
      if (dmem_req_o) n_req++;
      if (dmem_req_o && dmem_we_o) n_dwe++;
      if (retire_o) done = 1'b1;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL retire_timeout got=no_retire exp=retire"); end
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    checks++; if (pc_o !== 8'h00 || ir_o !== 16'h0000) begin failures++; $display("FAIL rst_pc_ir got=%h/%h exp=00/0000", pc_o, ir_o); end
    checks++; if ({flag_carry_o, flag_zero_o} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {flag_carry_o, flag_zero_o}); end
    checks++;
    if ({imem_req_o, dmem_req_o, dmem_we_o, reg_we_o, retire_o, bus_err_o} !== 6'b0) begin
      failures++; $display("FAIL rst_strobes got=%b exp=000000", {imem_req_o, dmem_req_o, dmem_we_o, reg_we_o, retire_o, bus_err_o});
    end
    repeat (3) @(negedge clk);
    checks++; if (state_o !== 3'd0 || imem_req_o !== 1'b0) begin failures++; $display("FAIL idle_hold got=%0d/%b exp=0/0", state_o, imem_req_o); end
  endtask

  task automatic test_alu();
    int cyc, nwe, nreq, ndwe;
    reset_dut();
    prog[0] = 16'h8A5C; alu_carry_i = 1'b1; alu_zero_i = 1'b0; run_i = 1'b1;
    wait_retire(cyc, nwe, nreq, ndwe);
    checks++; if (cyc != 4) begin failures++; $display("FAIL alu_cycles got=%0d exp=4", cyc); end
    checks++; if (nwe != 1) begin failures++; $display("FAIL alu_reg_we got=%0d exp=1", nwe); end
    checks++; if (ir_o !== 16'h8A5C || opcode_o !== 4'h8) begin failures++; $display("FAIL alu_ir got=%h/%h exp=8a5c/8", ir_o, opcode_o); end
    @(posedge clk); #1;
    checks++; if (pc_o !== 8'h01) begin failures++; $display("FAIL alu_pc got=%h exp=01", pc_o); end
    checks++; if ({flag_carry_o, flag_zero_o} !== 2'b10) begin failures++; $display("FAIL alu_flags got=%b exp=10", {flag_carry_o, flag_zero_o}); end
  endtask

  task automatic test_back_to_back_jumps();
    int cyc, nwe, nreq, ndwe;
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'h40; exp_pc[1] = 8'h41; exp_pc[2] = 8'h42; exp_pc[3] = 8'h50;
    reset_dut();
    prog[0] = 16'h8000; prog[1] = 16'h4040;
    prog[8'h40] = 16'h5420; prog[8'h41] = 16'h5860; prog[8'h42] = 16'h5050;
    alu_carry_i = 1'b0; alu_zero_i = 1'b1; run_i = 1'b1;
    wait_retire(cyc, nwe, nreq, ndwe);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      wait_retire(cyc, nwe, nreq, ndwe);
      checks++; if (cyc != 3) begin failures++; $display("FAIL jmp%0d_cycles got=%0d exp=3", k, cyc); end
      @(posedge clk); #1;
      checks++; if (pc_o !== exp_pc[k]) begin failures++; $display("FAIL jmp%0d_pc got=%h exp=%h", k, pc_o, exp_pc[k]); end
    end
  endtask

  task automatic test_mem();
    int cyc, nwe, nreq, ndwe;
    reset_dut();
    prog[0] = 16'h2000; prog[1] = 16'h3000; dmem_delay = 3; run_i = 1'b1;
    wait_retire(cyc, nwe, nreq, ndwe);
    dmem_delay = 0;
    checks++; if (cyc != 8) begin failures++; $display("FAIL ld_cycles got=%0d exp=8", cyc); end
    checks++; if (nreq != 4 || ndwe != 0) begin failures++; $display("FAIL ld_req got=%0d/%0d exp=4/0", nreq, ndwe); end
    checks++; if (nwe != 1) begin failures++; $display("FAIL ld_reg_we got=%0d exp=1", nwe); end
    @(posedge clk); #1;
    wait_retire(cyc, nwe, nreq, ndwe);
    checks++; if (cyc != 4) begin failures++; $display("FAIL st_cycles got=%0d exp=4", cyc); end
    checks++; if (nreq != 1 || ndwe != 1 || nwe != 0) begin failures++; $display("FAIL st_strobes got=%0d/%0d/%0d exp=1/1/0", nreq, ndwe, nwe); end
    @(posedge clk); #1;
    checks++; if (pc_o !== 8'h02) begin failures++; $display("FAIL st_pc got=%h exp=02", pc_o); end
  endtask

  task automatic test_timeout();
    int nreq = 0;
    bit hit = 1'b0;
    reset_dut();
    imem_en = 1'b0; run_i = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (bus_err_o) hit = 1'b1;
      else if (imem_req_o) nreq++;
    end
    checks++; if (!hit) begin failures++; $display("FAIL to_err got=0 exp=1"); end
    checks++; if (nreq != 15) begin failures++; $display("FAIL to_wait got=%0d exp=15", nreq); end
    checks++; if (state_o !== 3'd6 || imem_req_o !== 1'b0) begin failures++; $display("FAIL to_halt got=%0d/%b exp=6/0", state_o, imem_req_o); end
    imem_en = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (state_o !== 3'd6 || bus_err_o !== 1'b1 || imem_req_o !== 1'b0 || retire_o !== 1'b0) begin
      failures++; $display("FAIL to_hold got=%0d/%b/%b/%b exp=6/1/0/0", state_o, bus_err_o, imem_req_o, retire_o);
    end
    rst_ni = 1'b0; #1;
    checks++; if (bus_err_o !== 1'b0 || state_o !== 3'd0) begin failures++; $display("FAIL to_reset got=%b/%0d exp=0/0", bus_err_o, state_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_wrap_run_drop();
    int cyc, nwe, nreq, ndwe;
    bit done = 1'b0;
    reset_dut();
    prog[0] = 16'h40FF; prog[8'hFF] = 16'h8000; run_i = 1'b1;
    wait_retire(cyc, nwe, nreq, ndwe);
    @(posedge clk); #1;
    checks++; if (pc_o !== 8'hFF) begin failures++; $display("FAIL wrap_jmp_pc got=%h exp=ff", pc_o); end
    cyc = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (state_o == 3'd3) run_i = 1'b0;
      if (retire_o) done = 1'b1;
    end
    checks++; if (!done || cyc != 4) begin failures++; $display("FAIL drop_retire got=%0d/%0d exp=1/4", done, cyc); end
    @(posedge clk); #1;
    checks++; if (pc_o !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%h exp=00", pc_o); end
    repeat (3) @(negedge clk);
    checks++; if (state_o !== 3'd0 || imem_req_o !== 1'b0) begin failures++; $display("FAIL drop_idle got=%0d/%b exp=0/0", state_o, imem_req_o); end
  endtask

  task automatic test_reset_mid_mem();
    bit seen = 1'b0;
    reset_dut();
    prog[0] = 16'h2000; dmem_delay = 10; alu_carry_i = 1'b1; run_i = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (state_o == 3'd4) seen = 1'b1;
    end
    checks++; if (!seen || dmem_req_o !== 1'b1) begin failures++; $display("FAIL mid_req got=%b/%b exp=1/1", seen, dmem_req_o); end
    rst_ni = 1'b0; #1;
    checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL mid_req_drop got=%b exp=0", dmem_req_o); end
    checks++;
    if (state_o !== 3'd0 || pc_o !== 8'h00 || ir_o !== 16'h0000 || reg_we_o !== 1'b0 || retire_o !== 1'b0 || dmem_we_o !== 1'b0) begin
      failures++; $display("FAIL mid_reset_vals got=%0d/%h/%h exp=0/00/0000", state_o, pc_o, ir_o);
    end
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back_jumps();
    test_mem();
    test_timeout();
    test_wrap_run_drop();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
